imm_decode_stage: RTL and testbench

Registered, handshaked immediate-generation stage for the Mini-RISC-V decoder pipeline. Decodes every RV32I immediate format (I, S, B, U, J) from one instruction word per cycle, sign-extends it to a configurable XLEN, and classifies the format. Results are held in an output register plus a one-entry skid buffer, so fetch and execute stall independently. Sits between the instruction fetch register and the execute-stage operand mux.

---
 rtl/immgen_pkg.sv | 32 +++
 rtl/imm_extract.sv | 68 ++++++
 rtl/imm_decode_stage.sv | 115 +++++++++++
 tb/tb_imm_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared types and opcode constants for the immediate-generation stage.
// Build option IMMGEN_ZICSR_EN (used in imm_extract) enables the FMT_Z decode.
package immgen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   // Opcode constants are ins[6:2]; ins[1:0] must be 2'b11 for a 32-bit encoding.
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   // Width-independent part of a held entry; imm and tag are sized by the top.
   typedef struct packed {
      imm_fmt_e fmt;
      logic     illegal;
   } imm_entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I immediate extraction and sign extension to XLEN.
// With IMMGEN_ZICSR_EN defined, CSR*I instructions yield FMT_Z (zext rs1 field).
module imm_extract
   import immgen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     ins,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt,
   output logic            illegal
);

   logic [31:0] imm32;

   always_comb begin
      imm32   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      if (ins[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (ins[6:2])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
               fmt   = FMT_I;
               imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            OPC_STORE: begin
               fmt   = FMT_S;
               imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OPC_BRANCH: begin
               fmt   = FMT_B;
               imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
               fmt   = FMT_U;
               imm32 = {ins[31:12], 12'b0};
            end
            OPC_JAL: begin
               fmt   = FMT_J;
               imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
               if (ins[14]) begin
                  fmt   = FMT_Z;
                  imm32 = {27'b0, ins[19:15]};
               end else begin
                  fmt   = FMT_I;
                  imm32 = {{20{ins[31]}}, ins[31:20]};
               end
`else
               fmt   = FMT_I;
               imm32 = {{20{ins[31]}}, ins[31:20]};
`endif
            end
            default: begin
               illegal = 1'b1;
            end
         endcase
      end
   end

   // Every 32-bit form already carries its sign in bit 31, so one signed widen covers XLEN=64.
   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: output register plus one-entry skid buffer.
// Optional Zicsr decode is selected with IMMGEN_ZICSR_EN (see imm_extract).
module imm_decode_stage
   import immgen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ins,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_e         out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  dec_imm;
   imm_fmt_e         dec_fmt;
   logic             dec_illegal;
   imm_entry_t       dec_entry;

   logic             or_valid, sk_valid;
   logic [XLEN-1:0]  or_imm, sk_imm;
   imm_entry_t       or_entry, sk_entry;
   logic [TAG_W-1:0] or_tag, sk_tag;

   logic accept, drain;
   logic or_load_sk, or_load_in, sk_load;
   logic or_valid_next, sk_valid_next;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .ins     (in_ins),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign dec_entry = '{fmt: dec_fmt, illegal: dec_illegal};

   assign accept = in_valid & in_ready;
   assign drain  = or_valid & out_ready;

   // A held skid entry always moves ahead of the input so acceptance order is preserved.
   always_comb begin
      or_load_sk    = 1'b0;
      or_load_in    = 1'b0;
      sk_load       = 1'b0;
      or_valid_next = or_valid;
      sk_valid_next = sk_valid;
      if (!or_valid || drain) begin
         if (sk_valid) begin
            or_load_sk    = 1'b1;
            or_valid_next = 1'b1;
            sk_load       = accept;
            sk_valid_next = accept;
         end else begin
            or_load_in    = accept;
            or_valid_next = accept;
         end
      end else if (accept) begin
         sk_load       = 1'b1;
         sk_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         or_valid <= 1'b0;
         sk_valid <= 1'b0;
         in_ready <= 1'b1;
         or_imm   <= '0;
         or_entry <= '{fmt: FMT_NONE, illegal: 1'b0};
         or_tag   <= '0;
         sk_imm   <= '0;
         sk_entry <= '{fmt: FMT_NONE, illegal: 1'b0};
         sk_tag   <= '0;
      end else if (flush) begin
         or_valid <= 1'b0;
         sk_valid <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         or_valid <= or_valid_next;
         sk_valid <= sk_valid_next;
         in_ready <= !sk_valid_next;
         if (or_load_sk) begin
            or_imm   <= sk_imm;
            or_entry <= sk_entry;
            or_tag   <= sk_tag;
         end else if (or_load_in) begin
            or_imm   <= dec_imm;
            or_entry <= dec_entry;
            or_tag   <= in_tag;
         end
         if (sk_load) begin
            sk_imm   <= dec_imm;
            sk_entry <= dec_entry;
            sk_tag   <= in_tag;
         end
      end
   end

   assign out_valid   = or_valid;
   assign out_imm     = or_imm;
   assign out_fmt     = or_entry.fmt;
   assign out_illegal = or_entry.illegal;
   assign out_tag     = or_tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: FIFO scoreboard plus directed literal checks.
// Zicsr expectations follow IMMGEN_ZICSR_EN.
module tb_imm_decode_stage;
   import immgen_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_ins = '0;
   logic [31:0] in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_imm;
   imm_fmt_e    out_fmt;
   logic        out_illegal;
   logic [31:0] out_tag;

   logic        in_valid64 = 1'b0;
   logic        in_ready64;
   logic [31:0] in_ins64 = '0;
   logic [31:0] in_tag64 = '0;
   logic        out_valid64;
   logic [63:0] out_imm64;
   imm_fmt_e    out_fmt64;
   logic        out_illegal64;
   logic [31:0] out_tag64;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      logic [63:0] imm;
      imm_fmt_e    fmt;
      logic        ill;
      logic [31:0] tag;
   } exp_t;

   exp_t expQ[$];

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
   );

   imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_ins(in_ins64), .in_tag(in_tag64),
      .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference decode written from the ISA field layout with signed arithmetic.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] tag);
      exp_t   e;
      longint s;
      s = longint'($signed(ins));
      e.imm = 64'd0;
      e.fmt = FMT_NONE;
      e.ill = 1'b0;
      e.tag = tag;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67: begin e.fmt = FMT_I; e.imm = s >>> 20; end
         7'h23: begin
            e.fmt = FMT_S;
            e.imm = ((s >>> 25) << 5) + longint'(ins[11:7]);
         end
         7'h63: begin
            e.fmt = FMT_B;
            e.imm = ((s >>> 31) << 12) + (longint'(ins[7]) << 11)
                  + (longint'(ins[30:25]) << 5) + (longint'(ins[11:8]) << 1);
         end
         7'h37, 7'h17: begin e.fmt = FMT_U; e.imm = (s >>> 12) << 12; end
         7'h6F: begin
            e.fmt = FMT_J;
            e.imm = ((s >>> 31) << 20) + (longint'(ins[19:12]) << 12)
                  + (longint'(ins[20]) << 11) + (longint'(ins[30:21]) << 1);
         end
         7'h73: begin
`ifdef IMMGEN_ZICSR_EN
            if (ins[14]) begin e.fmt = FMT_Z; e.imm = longint'(ins[19:15]); end
            else begin e.fmt = FMT_I; e.imm = s >>> 20; end
`else
            e.fmt = FMT_I; e.imm = s >>> 20;
`endif
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Scoreboard: occupancy predicts the handshake, drains pop in acceptance order.
   always @(negedge clk) begin
      exp_t e;
      if (rst || flush) begin
         expQ.delete();
      end else begin
         checkOutput("sbOutValid", 64'(out_valid), 64'(expQ.size() > 0));
         checkOutput("sbInReady", 64'(in_ready), 64'(expQ.size() < 2));
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("sbUnexpectedDrain", 64'(out_tag), 64'hDEAD);
            end else begin
               e = expQ.pop_front();
               checkOutput("sbTag", 64'(out_tag), 64'(e.tag));
               checkOutput("sbImm", 64'(out_imm), 64'(e.imm[31:0]));
               checkOutput("sbFmt", 64'(out_fmt), 64'(e.fmt));
               checkOutput("sbIllegal", 64'(out_illegal), 64'(e.ill));
            end
         end
         if (in_valid && in_ready) expQ.push_back(model(in_ins, in_tag));
      end
   end

   task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] tag);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_ins   = ins;
      in_tag   = tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic checkReset(input string pfx);
      checkOutput({pfx, "OutValid"}, 64'(out_valid), 64'd0);
      checkOutput({pfx, "InReady"}, 64'(in_ready), 64'd1);
      checkOutput({pfx, "Imm"}, 64'(out_imm), 64'd0);
      checkOutput({pfx, "Fmt"}, 64'(out_fmt), 64'(FMT_NONE));
      checkOutput({pfx, "Illegal"}, 64'(out_illegal), 64'd0);
      checkOutput({pfx, "Tag"}, 64'(out_tag), 64'd0);
   endtask

   logic [31:0] vecs [9] = '{32'hFFF00093, 32'hFE20AE23, 32'h00000463, 32'hFFDFF0EF,
                            32'h123452B7, 32'h0000007F, 32'h3002D073, 32'h00000012,
                            32'hABCDE017};
   logic        readyPat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   task automatic decodeCheck(input logic [31:0] ins, input logic [31:0] tag,
                              input logic [31:0] imm, input imm_fmt_e fmt, input logic ill);
      applyStimulus(ins, tag);
      @(negedge clk);
      checkOutput("decValid", 64'(out_valid), 64'd1);
      checkOutput("decTag", 64'(out_tag), 64'(tag));
      checkOutput("decImm", 64'(out_imm), 64'(imm));
      checkOutput("decFmt", 64'(out_fmt), 64'(fmt));
      checkOutput("decIllegal", 64'(out_illegal), 64'(ill));
   endtask

   initial begin
      exp_t pin;
      int   cyc;
      logic acc;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkReset("rst");

      pin = model(32'hFFF00093, 0);
      checkOutput("pinModelI", pin.imm, 64'hFFFFFFFFFFFFFFFF);
      pin = model(32'h00000463, 0);
      checkOutput("pinModelB", pin.imm, 64'h8);
      pin = model(32'hFFDFF0EF, 0);
      checkOutput("pinModelJ", pin.imm, 64'hFFFFFFFFFFFFFFFC);
      pin = model(32'h800002B7, 0);
      checkOutput("pinModelU64", pin.imm, 64'hFFFFFFFF80000000);

      decodeCheck(32'hFFF00093, 32'h10, 32'hFFFFFFFF, FMT_I, 1'b0);
      decodeCheck(32'hFE20AE23, 32'h11, 32'hFFFFFFFC, FMT_S, 1'b0);
      decodeCheck(32'h00000463, 32'h12, 32'h00000008, FMT_B, 1'b0);
      decodeCheck(32'hFFDFF0EF, 32'h13, 32'hFFFFFFFC, FMT_J, 1'b0);
      decodeCheck(32'h123452B7, 32'h14, 32'h12345000, FMT_U, 1'b0);
      decodeCheck(32'h0000007F, 32'h15, 32'h0, FMT_NONE, 1'b1);
`ifdef IMMGEN_ZICSR_EN
      decodeCheck(32'h3002D073, 32'h16, 32'h5, FMT_Z, 1'b0);
`else
      decodeCheck(32'h3002D073, 32'h16, 32'h300, FMT_I, 1'b0);
`endif

      @(posedge clk); #1;
      in_valid64 = 1'b1; in_ins64 = 32'h800002B7; in_tag64 = 32'h64;
      @(posedge clk); #1;
      in_valid64 = 1'b0;
      @(negedge clk);
      checkOutput("x64Valid", 64'(out_valid64), 64'd1);
      checkOutput("x64Imm", out_imm64, 64'hFFFFFFFF80000000);
      checkOutput("x64Fmt", 64'(out_fmt64), 64'(FMT_U));
      checkOutput("x64Tag", 64'(out_tag64), 64'h64);

      // Backpressure: tags 1..3 back to back while the consumer stalls.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_ins = 32'hFFF00093; in_tag = 1;
      @(posedge clk); #1 in_tag = 2;
      @(posedge clk); #1 in_tag = 3;
      @(negedge clk);
      checkOutput("bpInReadyLow", 64'(in_ready), 64'd0);
      checkOutput("bpHeadTag", 64'(out_tag), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bpStillLow", 64'(in_ready), 64'd0);
      checkOutput("bpHeadStable", 64'(out_tag), 64'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bpSecondTag", 64'(out_tag), 64'd2);
      checkOutput("bpInReadyBack", 64'(in_ready), 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bpThirdTag", 64'(out_tag), 64'd3);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("bpEmpty", 64'(out_valid), 64'd0);

      // Flush with both entries full and a pending input.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 7;
      @(posedge clk); #1 in_tag = 8;
      @(posedge clk); #1 in_tag = 9; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      checkOutput("flOutValid", 64'(out_valid), 64'd0);
      checkOutput("flInReady", 64'(in_ready), 64'd1);
      // Flush while an accept would occur with only the output entry held.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 10;
      @(posedge clk); #1 in_tag = 11; flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("flNoOutput", 64'(out_valid), 64'd0);
      end

      // Reset mid-stream, then a fresh instruction right after.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_tag = 20;
      @(posedge clk); #1 in_tag = 21;
      @(posedge clk); #1 in_tag = 22; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_ins = 32'h123452B7; in_tag = 23;
      @(negedge clk);
      checkReset("midRst");
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("postRstValid", 64'(out_valid), 64'd1);
      checkOutput("postRstTag", 64'(out_tag), 64'd23);
      checkOutput("postRstImm", 64'(out_imm), 64'h12345000);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;

      // Burst under a stall pattern; the scoreboard checks every drain.
      cyc = 0;
      for (int i = 0; i < 18; i++) begin
         in_valid = 1'b1;
         in_ins   = vecs[i % 9];
         in_tag   = 32'd100 + 32'(i);
         acc      = 1'b0;
         for (int k = 0; k < 20 && !acc; k++) begin
            out_ready = readyPat[cyc % 7];
            cyc++;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
         end
         if (!acc) checkOutput("burstAcceptTimeout", 64'd0, 64'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("burstDrained", 64'(expQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
